mem_arbiter: RTL and testbench

Two-port arbiter that shares the single memory controller port (ROM 0–119999, RAM 120000–240999, switch registers 241000–241020) between the vector core and the display readout engine. Requests are round-robin arbitrated, one at a time. Each transaction is sequenced through a fixed issue/wait/done state machine, so the memory sees a stable address for the whole access. CPU writes outside the RAM window are blocked and flagged.

---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory controller port between the vector core (CPU)
// and the display readout engine. One transaction at a time, round-robin on a
// tie, sequenced IDLE -> ISSUE -> (WAIT) -> DONE so the memory sees a stable
// address for the whole access. CPU writes outside the RAM window are blocked
// and reported on cpu_err together with cpu_done.
module mem_arbiter #(
    parameter int unsigned  RD_LAT   = 1,
    parameter logic [127:0] RAM_BASE = 128'd120000,
    parameter logic [127:0] RAM_TOP  = 128'd240999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic         cpu_vf,
    input  logic [127:0] cpu_addr,
    input  logic [127:0] cpu_wd,
    output logic         cpu_gnt,
    output logic         cpu_done,
    output logic         cpu_err,
    output logic [127:0] cpu_rdata,
    input  logic         disp_req,
    input  logic [127:0] disp_addr,
    output logic         disp_gnt,
    output logic         disp_done,
    output logic [127:0] disp_rdata,
    output logic         mem_we,
    output logic         mem_vf,
    output logic [127:0] mem_addr,
    output logic [127:0] mem_wd,
    input  logic [127:0] mem_rd,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned      CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic             OWN_DISP = 1'b0;
    localparam logic             OWN_CPU  = 1'b1;

    // A CPU write is blocked when it falls outside the RAM window.
    function automatic logic wr_blocked(input logic we, input logic [127:0] addr);
        return we & ((addr < RAM_BASE) | (addr > RAM_TOP));
    endfunction

    state_t           state_q,      state_d;
    logic             last_owner_q, last_owner_d;
    logic             owner_q,      owner_d;
    logic             we_q,         we_d;
    logic             blocked_q,    blocked_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             mem_we_q,     mem_we_d;
    logic             mem_vf_q,     mem_vf_d;
    logic [127:0]     mem_addr_q,   mem_addr_d;
    logic [127:0]     mem_wd_q,     mem_wd_d;
    logic             cpu_gnt_q,    cpu_gnt_d;
    logic             disp_gnt_q,   disp_gnt_d;
    logic             cpu_done_q,   cpu_done_d;
    logic             disp_done_q,  disp_done_d;
    logic             cpu_err_q,    cpu_err_d;
    logic [127:0]     cpu_rdata_q,  cpu_rdata_d;
    logic [127:0]     disp_rdata_q, disp_rdata_d;
    logic             busy_q,       busy_d;
    logic             win_cpu_s;

    // Next state, transaction latch and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        blocked_d    = blocked_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;
        mem_vf_d     = mem_vf_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        cpu_gnt_d    = 1'b0;
        disp_gnt_d   = 1'b0;
        cpu_done_d   = 1'b0;
        disp_done_d  = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        disp_rdata_d = disp_rdata_q;
        // CPU wins alone, or on a tie when the display owned the last transaction.
        win_cpu_s    = cpu_req & (~disp_req | (last_owner_q == OWN_DISP));

        case (state_q)
            S_IDLE: begin
                if (cpu_req | disp_req) begin
                    state_d      = S_ISSUE;
                    owner_d      = win_cpu_s ? OWN_CPU : OWN_DISP;
                    last_owner_d = win_cpu_s ? OWN_CPU : OWN_DISP;
                    if (win_cpu_s) begin
                        we_d       = cpu_we;
                        blocked_d  = wr_blocked(cpu_we, cpu_addr);
                        mem_vf_d   = cpu_vf;
                        mem_addr_d = cpu_addr;
                        mem_wd_d   = cpu_wd;
                        mem_we_d   = cpu_we & ~wr_blocked(cpu_we, cpu_addr);
                        cpu_gnt_d  = 1'b1;
                    end else begin
                        // Display traffic is always a plain read.
                        we_d       = 1'b0;
                        blocked_d  = 1'b0;
                        mem_vf_d   = 1'b0;
                        mem_addr_d = disp_addr;
                        mem_wd_d   = 128'd0;
                        disp_gnt_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_CPU) begin
                        cpu_done_d = 1'b1;
                        cpu_err_d  = blocked_q;
                    end else begin
                        disp_done_d = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = mem_rd;
                        cpu_done_d  = 1'b1;
                    end else begin
                        disp_rdata_d = mem_rd;
                        disp_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, latch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_DISP;
            owner_q      <= OWN_DISP;
            we_q         <= 1'b0;
            blocked_q    <= 1'b0;
            cnt_q        <= CNT_ZERO;
            mem_we_q     <= 1'b0;
            mem_vf_q     <= 1'b0;
            mem_addr_q   <= 128'd0;
            mem_wd_q     <= 128'd0;
            cpu_gnt_q    <= 1'b0;
            disp_gnt_q   <= 1'b0;
            cpu_done_q   <= 1'b0;
            disp_done_q  <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= 128'd0;
            disp_rdata_q <= 128'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            blocked_q    <= blocked_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_vf_q     <= mem_vf_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            cpu_gnt_q    <= cpu_gnt_d;
            disp_gnt_q   <= disp_gnt_d;
            cpu_done_q   <= cpu_done_d;
            disp_done_q  <= disp_done_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_rdata_q <= disp_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign cpu_done   = cpu_done_q;
    assign cpu_err    = cpu_err_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign disp_gnt   = disp_gnt_q;
    assign disp_done  = disp_done_q;
    assign disp_rdata = disp_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_vf     = mem_vf_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter. A
// transaction-level model predicts every output from request timing; a second
// instance with RD_LAT=3 covers the longer read latency.
module tb_mem_arbiter;

    localparam int unsigned  LAT       = 1;
    localparam logic [127:0] RAM_LO    = 128'd120000;
    localparam logic [127:0] RAM_HI    = 128'd240999;
    localparam int           RAND_CYC  = 3000;

    logic clk;
    logic rst;
    logic cpu_req, cpu_we, cpu_vf, disp_req;
    logic [127:0] cpu_addr, cpu_wd, disp_addr;
    logic cpu_gnt, cpu_done, cpu_err, disp_gnt, disp_done, mem_we, mem_vf, busy;
    logic [127:0] cpu_rdata, disp_rdata, mem_addr, mem_wd, mem_rd;

    logic rst_3;
    logic cpu_req_3, cpu_we_3, cpu_vf_3, disp_req_3;
    logic [127:0] cpu_addr_3, cpu_wd_3, disp_addr_3;
    logic cpu_gnt_3, cpu_done_3, cpu_err_3, disp_gnt_3, disp_done_3, mem_we_3, mem_vf_3, busy_3;
    logic [127:0] cpu_rdata_3, disp_rdata_3, mem_addr_3, mem_wd_3, mem_rd_3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory contents seen by both instances
    function automatic logic [127:0] mem_fn(input logic [127:0] a);
        if (a == 128'd120005) return 128'hA5;
        return (a * 128'd2654435761) ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    mem_arbiter #(.RD_LAT(LAT), .RAM_BASE(RAM_LO), .RAM_TOP(RAM_HI)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vf(cpu_vf), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_done(disp_done),
        .disp_rdata(disp_rdata), .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    mem_arbiter #(.RD_LAT(3), .RAM_BASE(RAM_LO), .RAM_TOP(RAM_HI)) dut3 (
        .clk(clk), .rst(rst_3),
        .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_vf(cpu_vf_3), .cpu_addr(cpu_addr_3), .cpu_wd(cpu_wd_3),
        .cpu_gnt(cpu_gnt_3), .cpu_done(cpu_done_3), .cpu_err(cpu_err_3), .cpu_rdata(cpu_rdata_3),
        .disp_req(disp_req_3), .disp_addr(disp_addr_3), .disp_gnt(disp_gnt_3), .disp_done(disp_done_3),
        .disp_rdata(disp_rdata_3), .mem_we(mem_we_3), .mem_vf(mem_vf_3), .mem_addr(mem_addr_3),
        .mem_wd(mem_wd_3), .mem_rd(mem_rd_3), .busy(busy_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory models: data for an address appears RD_LAT cycles after it is presented
    logic [127:0] pipe1_q;
    logic [127:0] pipe3_q [0:2];
    always @(posedge clk) begin
        pipe1_q    <= mem_addr;
        pipe3_q[0] <= mem_addr_3;
        pipe3_q[1] <= pipe3_q[0];
        pipe3_q[2] <= pipe3_q[1];
    end
    assign mem_rd   = mem_fn(pipe1_q);
    assign mem_rd_3 = mem_fn(pipe3_q[2]);

    // ---------------- transaction-level model of the main instance ----------------
    bit           m_rst_pend = 1'b0;
    bit           m_active   = 1'b0;
    int           m_s = 0, m_done_c = 0, m_free_at = 0;
    bit           m_is_wr, m_cpu_own, m_blk, m_vf, m_last_cpu = 1'b0;
    logic [127:0] m_addr, m_wd, m_rdat;
    bit           e_busy, e_cpu_gnt, e_disp_gnt, e_cpu_done, e_disp_done, e_err, e_we, e_vf;
    logic [127:0] e_addr, e_wd, e_crd, e_drd;

    task automatic model_sample();
        bit pick_cpu;
        if (!rst) begin
            m_rst_pend = 1'b1;
        end else if (cyc >= m_free_at && (cpu_req || disp_req)) begin
            pick_cpu = cpu_req && (!disp_req || !m_last_cpu);
            m_active = 1'b1;
            m_s = cyc;
            m_cpu_own = pick_cpu;
            if (pick_cpu) begin
                m_is_wr = cpu_we; m_vf = cpu_vf; m_addr = cpu_addr; m_wd = cpu_wd;
                m_blk = cpu_we && (cpu_addr < RAM_LO || cpu_addr > RAM_HI);
            end else begin
                m_is_wr = 1'b0; m_vf = 1'b0; m_addr = disp_addr; m_wd = 128'd0; m_blk = 1'b0;
            end
            m_rdat = mem_fn(m_addr);
            m_done_c = m_is_wr ? cyc + 2 : cyc + int'(LAT) + 2;
            m_free_at = m_done_c + 1;
            m_last_cpu = pick_cpu;
        end
    endtask

    task automatic model_outputs();
        e_cpu_gnt = 1'b0; e_disp_gnt = 1'b0; e_cpu_done = 1'b0; e_disp_done = 1'b0;
        e_err = 1'b0; e_we = 1'b0;
        if (m_rst_pend) begin
            m_rst_pend = 1'b0; m_active = 1'b0; m_free_at = cyc; m_last_cpu = 1'b0;
            e_busy = 1'b0; e_vf = 1'b0; e_addr = 128'd0; e_wd = 128'd0;
            e_crd = 128'd0; e_drd = 128'd0;
        end else begin
            e_busy = m_active && cyc > m_s && cyc <= m_done_c;
            if (m_active && cyc == m_s + 1) begin
                e_addr = m_addr; e_wd = m_wd; e_vf = m_vf;
                e_we = m_is_wr && !m_blk;
                if (m_cpu_own) e_cpu_gnt = 1'b1; else e_disp_gnt = 1'b1;
            end
            if (m_active && cyc == m_done_c) begin
                if (m_cpu_own) e_cpu_done = 1'b1; else e_disp_done = 1'b1;
                e_err = m_blk;
                if (!m_is_wr) begin
                    if (m_cpu_own) e_crd = m_rdat; else e_drd = m_rdat;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk1("busy", busy, e_busy);
        chk1("cpu_gnt", cpu_gnt, e_cpu_gnt);
        chk1("cpu_done", cpu_done, e_cpu_done);
        chk1("cpu_err", cpu_err, e_err);
        chk1("disp_gnt", disp_gnt, e_disp_gnt);
        chk1("disp_done", disp_done, e_disp_done);
        chk1("mem_we", mem_we, e_we);
        chk1("mem_vf", mem_vf, e_vf);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wd", mem_wd, e_wd);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("disp_rdata", disp_rdata, e_drd);
    endtask

    // one clock: model samples inputs, edge, outputs settle, compare
    task automatic step();
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
        model_outputs();
        compare_all();
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0; cpu_req = 1'b0; disp_req = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    task automatic dir_read(input logic [127:0] a, input logic [127:0] exp_rd);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_vf = 1'b0; cpu_addr = a; cpu_wd = 128'd0;
        step();
        chk1("rd_gnt_t1", cpu_gnt, 1'b1);
        chk1("rd_disp_gnt_t1", disp_gnt, 1'b0);
        chk("rd_addr_t1", mem_addr, a);
        cpu_req = 1'b0;
        step();
        chk1("rd_busy_t2", busy, 1'b1);
        chk1("rd_done_t2", cpu_done, 1'b0);
        step();
        chk1("rd_done_t3", cpu_done, 1'b1);
        chk("rd_rdata_t3", cpu_rdata, exp_rd);
        chk1("rd_disp_done_t3", disp_done, 1'b0);
        step();
        chk1("rd_idle_t4", busy, 1'b0);
    endtask

    task automatic dir_write(input logic [127:0] a, input logic [127:0] wd, input logic exp_we);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_vf = 1'b1; cpu_addr = a; cpu_wd = wd;
        step();
        chk1("wr_gnt_t1", cpu_gnt, 1'b1);
        chk1("wr_mem_we_t1", mem_we, exp_we);
        chk("wr_mem_addr_t1", mem_addr, a);
        chk("wr_mem_wd_t1", mem_wd, wd);
        cpu_req = 1'b0;
        step();
        chk1("wr_done_t2", cpu_done, 1'b1);
        chk1("wr_err_t2", cpu_err, !exp_we);
        chk1("wr_mem_we_t2", mem_we, 1'b0);
        step();
        chk1("wr_idle_t3", busy, 1'b0);
    endtask

    function automatic logic [127:0] rand_addr();
        logic [127:0] edges [4];
        edges[0] = 128'd119999; edges[1] = 128'd120000; edges[2] = 128'd240999; edges[3] = 128'd241000;
        case ($urandom_range(0, 5))
            0: return 128'($urandom_range(0, 119999));
            1: return 128'($urandom_range(120000, 240999));
            2: return 128'($urandom_range(241000, 241020));
            3: return edges[$urandom_range(0, 3)];
            4: return {$urandom, $urandom, $urandom, $urandom};
            default: return 128'd120000 + 128'($urandom_range(0, 5));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tie_order [4];
        int k;
        bit cpu_pend, disp_pend;
        tie_order[0] = 1'b1; tie_order[1] = 1'b0; tie_order[2] = 1'b1; tie_order[3] = 1'b0;

        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_vf = 1'b0; cpu_addr = 128'd0; cpu_wd = 128'd0;
        disp_req = 1'b0; disp_addr = 128'd0;
        rst_3 = 1'b0; cpu_req_3 = 1'b0; cpu_we_3 = 1'b0; cpu_vf_3 = 1'b0; cpu_addr_3 = 128'd0;
        cpu_wd_3 = 128'd0; disp_req_3 = 1'b0; disp_addr_3 = 128'd0;

        // reset values
        apply_reset(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk("rst_mem_addr", mem_addr, 128'd0);
        chk("rst_cpu_rdata", cpu_rdata, 128'd0);

        // directed reads and writes
        dir_read(128'd120005, 128'hA5);
        dir_write(128'd130000, 128'h1234, 1'b1);
        dir_write(128'd500, 128'hBEEF, 1'b0);
        dir_write(128'd241000, 128'hCAFE, 1'b0);

        // reset during the WAIT of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_vf = 1'b0; cpu_addr = 128'd120300; cpu_wd = 128'd0;
        step();
        chk1("rw_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        step();
        chk1("rw_busy_wait", busy, 1'b1);
        rst = 1'b0;
        step();
        chk1("rw_busy_after", busy, 1'b0);
        chk1("rw_no_done", cpu_done, 1'b0);
        chk("rw_rdata_cleared", cpu_rdata, 128'd0);
        rst = 1'b1;
        dir_read(128'd120005, 128'hA5);

        // continuous contention from reset
        apply_reset(2);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_vf = 1'b1; cpu_addr = 128'd120100; cpu_wd = 128'h77;
        disp_req = 1'b1; disp_addr = 128'd150000;
        k = 0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            step();
            if (e_cpu_gnt || e_disp_gnt) begin
                chk1("tie_model_owner", e_cpu_gnt, tie_order[k]);
                chk1("tie_cpu_gnt", cpu_gnt, tie_order[k]);
                chk1("tie_disp_gnt", disp_gnt, !tie_order[k]);
                k++;
                if (e_cpu_gnt) cpu_req = 1'b0; else disp_req = 1'b0;
            end
            if (e_cpu_done && k < 4) begin cpu_req = 1'b1; cpu_addr = cpu_addr + 128'd1; end
            if (e_disp_done && k < 4) begin disp_req = 1'b1; disp_addr = disp_addr + 128'd1; end
        end
        chk("tie_grant_count", 128'(k), 128'd4);
        cpu_req = 1'b0; disp_req = 1'b0;
        repeat (8) step();

        // randomized traffic with occasional resets
        cpu_pend = 1'b0; disp_pend = 1'b0;
        for (int n = 0; n < RAND_CYC + 200; n++) begin
            step();
            if (cpu_pend && e_cpu_gnt) begin cpu_pend = 1'b0; cpu_req = 1'b0; end
            if (disp_pend && e_disp_gnt) begin disp_pend = 1'b0; disp_req = 1'b0; end
            if (n >= RAND_CYC && !cpu_pend && !disp_pend) break;
            if (n < RAND_CYC && !cpu_pend && $urandom_range(0, 2) == 0) begin
                cpu_pend = 1'b1; cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1)); cpu_vf = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (n < RAND_CYC && !disp_pend && $urandom_range(0, 2) == 0) begin
                disp_pend = 1'b1; disp_req = 1'b1; disp_addr = rand_addr();
            end
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        end
        chk1("rand_drained", cpu_pend | disp_pend, 1'b0);
        rst = 1'b1; cpu_req = 1'b0; disp_req = 1'b0;
        repeat (8) step();

        // RD_LAT=3 instance: display read holds the address through ISSUE + 3 WAIT
        rst_3 = 1'b1;
        step();
        disp_req_3 = 1'b1; disp_addr_3 = 128'd200000;
        step();
        chk1("l3_gnt_t1", disp_gnt_3, 1'b1);
        chk("l3_addr_t1", mem_addr_3, 128'd200000);
        chk1("l3_we_t1", mem_we_3, 1'b0);
        disp_req_3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("l3_addr_wait", mem_addr_3, 128'd200000);
            chk1("l3_we_wait", mem_we_3, 1'b0);
            chk1("l3_done_early", disp_done_3, 1'b0);
            chk1("l3_busy_wait", busy_3, 1'b1);
        end
        step();
        chk1("l3_done_t5", disp_done_3, 1'b1);
        chk("l3_rdata_t5", disp_rdata_3, mem_fn(128'd200000));
        chk1("l3_cpu_done", cpu_done_3, 1'b0);
        chk1("l3_cpu_err", cpu_err_3, 1'b0);
        chk("l3_cpu_rdata", cpu_rdata_3, 128'd0);
        step();
        chk1("l3_idle", busy_3, 1'b0);
        chk1("l3_cpu_gnt", cpu_gnt_3, 1'b0);
        chk1("l3_vf", mem_vf_3, 1'b0);
        chk("l3_wd", mem_wd_3, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
